complex_div: RTL

- Sequential complex divider; the inverse operation of the combinational complex multiplier.
- Computes q = a / b for signed two's-complement WIDTH-bit complex operands: q = a*conj(b) / |b|^2.
- Both quotient parts are produced by one shared iterative restoring-divider loop running both divisions in parallel.
- Sits next to the multiplier in the datapath; start/done handshake with fixed latency.

---
 rtl/complex_div.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/complex_div.sv
// Sequential complex divider: q = a*conj(b)/|b|^2 via a shared restoring-divider loop.
// Build option COMPLEX_DIV_SAT_EN: saturate out-of-range quotients instead of wrapping.
module complex_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] aReal,
    input  logic [WIDTH-1:0] aImag,
    input  logic [WIDTH-1:0] bReal,
    input  logic [WIDTH-1:0] bImag,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] outReal,
    output logic [WIDTH-1:0] outImag,
    output logic             divZero
);

    localparam int NW = 2 * WIDTH;
    localparam logic [NW-1:0] CNT_LAST = NW'(NW - 1);

`ifdef COMPLEX_DIV_SAT_EN
    localparam logic signed [NW:0] Q_MAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [NW:0] Q_MIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREP,
        S_DIV,
        S_FIX
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_aRe, r_aIm, r_bRe, r_bIm;
    logic [NW-1:0]    r_qR, r_qI, r_remR, r_remI, r_den, r_cnt;
    logic             r_negR, r_negI, r_zero, r_done, r_divZero;
    logic [WIDTH-1:0] r_outRe, r_outIm;

    logic signed [NW:0] w_aReX, w_aImX, w_bReX, w_bImX;
    logic signed [NW:0] w_nr, w_ni, w_nrAbs, w_niAbs;
    logic [NW-1:0]      w_bReN, w_bImN, w_den;
    logic [2*NW-1:0]    w_stepR, w_stepI;
    logic signed [NW:0] w_sqR, w_sqI;
    logic [WIDTH-1:0]   w_outR, w_outI;
    logic               w_unused;

    // Sign-extend before multiplying so the products keep full precision
    assign w_aReX = {{(WIDTH+1){r_aRe[WIDTH-1]}}, r_aRe};
    assign w_aImX = {{(WIDTH+1){r_aIm[WIDTH-1]}}, r_aIm};
    assign w_bReX = {{(WIDTH+1){r_bRe[WIDTH-1]}}, r_bRe};
    assign w_bImX = {{(WIDTH+1){r_bIm[WIDTH-1]}}, r_bIm};

    assign w_nr    = w_aReX * w_bReX + w_aImX * w_bImX;
    assign w_ni    = w_aImX * w_bReX - w_aReX * w_bImX;
    assign w_nrAbs = w_nr[NW] ? -w_nr : w_nr;
    assign w_niAbs = w_ni[NW] ? -w_ni : w_ni;

    // |b|^2 never exceeds 2^(NW-1), so NW-bit arithmetic is exact
    assign w_bReN = {{WIDTH{r_bRe[WIDTH-1]}}, r_bRe};
    assign w_bImN = {{WIDTH{r_bIm[WIDTH-1]}}, r_bIm};
    assign w_den  = w_bReN * w_bReN + w_bImN * w_bImN;

    function automatic logic [2*NW-1:0] div_step(input logic [NW-1:0] rem,
                                                 input logic [NW-1:0] q,
                                                 input logic [NW-1:0] den);
        logic [NW:0] sh;
        sh = {rem, q[NW-1]};
        if (sh >= {1'b0, den})
            return {NW'(sh - {1'b0, den}), q[NW-2:0], 1'b1};
        else
            return {sh[NW-1:0], q[NW-2:0], 1'b0};
    endfunction

    assign w_stepR = div_step(r_remR, r_qR, r_den);
    assign w_stepI = div_step(r_remI, r_qI, r_den);

    assign w_sqR = r_negR ? -$signed({1'b0, r_qR}) : $signed({1'b0, r_qR});
    assign w_sqI = r_negI ? -$signed({1'b0, r_qI}) : $signed({1'b0, r_qI});

    always_comb begin
        w_outR = w_sqR[WIDTH-1:0];
        w_outI = w_sqI[WIDTH-1:0];
`ifdef COMPLEX_DIV_SAT_EN
        if (w_sqR > Q_MAX)
            w_outR = Q_MAX[WIDTH-1:0];
        else if (w_sqR < Q_MIN)
            w_outR = Q_MIN[WIDTH-1:0];
        if (w_sqI > Q_MAX)
            w_outI = Q_MAX[WIDTH-1:0];
        else if (w_sqI < Q_MIN)
            w_outI = Q_MIN[WIDTH-1:0];
`endif
    end

    assign w_unused = ^{w_nrAbs[NW], w_niAbs[NW], w_sqR[NW:WIDTH], w_sqI[NW:WIDTH]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_PREP;
            S_PREP:  w_next = S_DIV;
            S_DIV:   if (r_cnt == CNT_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aRe     <= '0;
            r_aIm     <= '0;
            r_bRe     <= '0;
            r_bIm     <= '0;
            r_qR      <= '0;
            r_qI      <= '0;
            r_remR    <= '0;
            r_remI    <= '0;
            r_den     <= '0;
            r_cnt     <= '0;
            r_negR    <= 1'b0;
            r_negI    <= 1'b0;
            r_zero    <= 1'b0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
            r_outRe   <= '0;
            r_outIm   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_aRe <= aReal;
                        r_aIm <= aImag;
                        r_bRe <= bReal;
                        r_bIm <= bImag;
                    end
                end
                S_PREP: begin
                    r_qR   <= w_nrAbs[NW-1:0];
                    r_qI   <= w_niAbs[NW-1:0];
                    r_negR <= w_nr[NW];
                    r_negI <= w_ni[NW];
                    r_den  <= w_den;
                    r_zero <= (w_den == '0);
                    r_remR <= '0;
                    r_remI <= '0;
                    r_cnt  <= '0;
                end
                S_DIV: begin
                    {r_remR, r_qR} <= w_stepR;
                    {r_remI, r_qI} <= w_stepI;
                    r_cnt          <= r_cnt + NW'(1);
                end
                S_FIX: begin
                    r_outRe   <= r_zero ? '0 : w_outR;
                    r_outIm   <= r_zero ? '0 : w_outI;
                    r_divZero <= r_zero;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign outReal = r_outRe;
    assign outImag = r_outIm;
    assign divZero = r_divZero;

endmodule
